bus_master_ctrl: RTL and testbench

- Command-driven bus master that drives one bus_if slave (e.g. the register slave) through a single-outstanding valid/ready transaction.
- Accepts read/write commands from a local requester and issues them on the bus.
- Collects ready/read_data and returns a response with an error flag when the slave never answers.
- Sits directly upstream of the slave on the same bus_if.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_if.sv | 15 +
 rtl/bus_timeout_cnt.sv | 37 +++
 rtl/bus_master_ctrl.sv | 126 ++++++++++++
 tb/tb_bus_master_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types and defaults for the bus master and its timeout counter.
// Struct fields use the widest supported bus; the master narrows them to its own ADDR_W/DATA_W.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W      = 32;
  localparam int unsigned BUS_DATA_W      = 32;
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                  read;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic [BUS_DATA_W-1:0] rdata;
    logic                  error;
  } rsp_t;

endpackage

// File: rtl/bus_if.sv
// Single-outstanding valid/ready bus between one master and one slave.
interface bus_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              read;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic              ready;
  logic [DATA_W-1:0] read_data;

  modport master (output valid, read, addr, write_data, input ready, read_data);
  modport slave  (input valid, read, addr, write_data, output ready, read_data);
endinterface

// File: rtl/bus_timeout_cnt.sv
// Counts bus-wait cycles; expired_o flags the last cycle allowed before the master aborts.
module bus_timeout_cnt
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at the terminal count so a stalled FSM can never see it wrap to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != TERMINAL)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == TERMINAL);

endmodule

// File: rtl/bus_master_ctrl.sv
// Command-to-bus bridge: issues one read/write at a time on bus_if and returns data or a timeout error.
module bus_master_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W         = BUS_ADDR_W,
  parameter int unsigned DATA_W         = BUS_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_read,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  bus_if.master             busc
);

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  rsp_t   rsp_q, rsp_d;
  logic   bus_valid_q, bus_valid_d;
  logic   cmd_ready_q, cmd_ready_d;
  logic   rsp_valid_q, rsp_valid_d;
  logic   cnt_clear, cnt_en, cnt_expired;

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .expired_o(cnt_expired)
  );

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    bus_valid_d = bus_valid_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_d       = '{read: cmd_read, addr: BUS_ADDR_W'(cmd_addr), wdata: BUS_DATA_W'(cmd_wdata)};
          rsp_d       = '0;
          bus_valid_d = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = ST_BUS;
        end
      end

      // Ready beats the terminal count when both land in the same cycle.
      ST_BUS: begin
        cnt_en = 1'b1;
        if (busc.ready) begin
          rsp_d.rdata = cmd_q.read ? BUS_DATA_W'(busc.read_data) : '0;
          rsp_d.error = 1'b0;
          bus_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_expired) begin
          rsp_d       = '{rdata: '0, error: 1'b1};
          bus_valid_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        bus_valid_d = 1'b0;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // NOTE: only control and output-visible registers exist here; all of them are reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      bus_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      bus_valid_q <= bus_valid_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = DATA_W'(rsp_q.rdata);
  assign rsp_error       = rsp_q.error;
  assign busc.valid      = bus_valid_q;
  assign busc.read       = cmd_q.read;
  assign busc.addr       = ADDR_W'(cmd_q.addr);
  assign busc.write_data = DATA_W'(cmd_q.wdata);

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Self-checking bench: behavioural slave with programmable ready latency plus a memory/timeout reference model.
module tb_bus_master_ctrl;
  import bus_pkg::*;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned TO  = 16;
  localparam logic [DW-1:0] DEF = 32'hCAFE_BABE;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_read;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_error;
  logic [DW-1:0] rsp_rdata;

  bus_if #(.ADDR_W(AW), .DATA_W(DW)) busc ();

  bus_master_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busc(busc)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Slave environment: ready goes high 'slave_lat' cycles after the first valid cycle.
  int slave_lat = 2;
  int vcnt      = 0;
  bit stray     = 1'b0;
  logic [DW-1:0] slave_mem [logic [AW-1:0]];
  // Reference model: expected memory contents seen through the master.
  logic [DW-1:0] model_mem [logic [AW-1:0]];

  initial begin
    busc.ready     = 1'b0;
    busc.read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || busc.valid !== 1'b1) begin
        vcnt           = 0;
        busc.ready     = stray;
        busc.read_data = $urandom;
      end else begin
        if (vcnt == slave_lat) begin
          busc.ready = 1'b1;
          if (busc.read) begin
            busc.read_data = slave_mem.exists(busc.addr) ? slave_mem[busc.addr] : DEF;
          end else begin
            busc.read_data = $urandom;
            slave_mem[busc.addr] = busc.write_data;
          end
        end else begin
          busc.ready     = 1'b0;
          busc.read_data = $urandom;
        end
        vcnt++;
      end
    end
  end

  // One complete transaction; called and returns on a negedge.
  task automatic do_txn(input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int lat, input int hold, input bit chain,
                        input bit n_rd, input logic [AW-1:0] n_a, input logic [DW-1:0] n_wd,
                        input string tag);
    int n, vcyc, exp_vcyc;
    bit exp_err;
    logic [DW-1:0] exp_data;

    exp_err  = (lat >= int'(TO));
    exp_vcyc = exp_err ? int'(TO) : lat + 1;
    exp_data = (exp_err || !rd) ? '0 : (model_mem.exists(a) ? model_mem[a] : DEF);
    if (!rd && !exp_err) model_mem[a] = wd;

    slave_lat = lat;
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (cmd_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL %s accept: cmd_ready=%b, required 1 within 50 cycles", tag, cmd_ready);
    end
    @(negedge clk);
    if (chain) begin
      cmd_read = n_rd; cmd_addr = n_a; cmd_wdata = n_wd;
    end else begin
      cmd_valid = 1'b0;
    end

    vcyc = 0;
    while (busc.valid === 1'b1 && vcyc < 300) begin
      compared++;
      if (busc.read !== rd || busc.addr !== a || (!rd && busc.write_data !== wd) ||
          cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL %s bus_fields: read=%b addr=%h wdata=%h cmd_ready=%b rsp_valid=%b, required read=%b addr=%h wdata=%h cmd_ready=0 rsp_valid=0",
                 tag, busc.read, busc.addr, busc.write_data, cmd_ready, rsp_valid, rd, a, wd);
      end
      vcyc++;
      @(negedge clk);
    end
    compared++;
    if (vcyc != exp_vcyc) begin
      mismatched++;
      $display("FAIL %s valid_len: %0d cycles, required %0d", tag, vcyc, exp_vcyc);
    end
    compared++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_data || rsp_error !== exp_err) begin
      mismatched++;
      $display("FAIL %s rsp: valid=%b rdata=%h error=%b, required valid=1 rdata=%h error=%b",
               tag, rsp_valid, rsp_rdata, rsp_error, exp_data, exp_err);
    end

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      compared++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_data || rsp_error !== exp_err ||
          cmd_ready !== 1'b0 || busc.valid !== 1'b0) begin
        mismatched++;
        $display("FAIL %s rsp_hold: valid=%b rdata=%h error=%b cmd_ready=%b bus_valid=%b, required 1/%h/%b/0/0",
                 tag, rsp_valid, rsp_rdata, rsp_error, cmd_ready, busc.valid, exp_data, exp_err);
      end
    end

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    compared++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busc.valid !== 1'b0) begin
      mismatched++;
      $display("FAIL %s rsp_done: rsp_valid=%b cmd_ready=%b bus_valid=%b, required 0/1/0",
               tag, rsp_valid, cmd_ready, busc.valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_error !== 1'b0 ||
        busc.valid !== 1'b0 || busc.read !== 1'b0 || busc.addr !== '0 || busc.write_data !== '0) begin
      mismatched++;
      $display("FAIL reset_values: cmd_ready=%b rsp_valid=%b rdata=%h err=%b bvalid=%b bread=%b baddr=%h bwdata=%h, required 1/0/0/0/0/0/0/0",
               cmd_ready, rsp_valid, rsp_rdata, rsp_error, busc.valid, busc.read, busc.addr, busc.write_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    do_txn(1'b1, 32'h10, '0, 2, 0, 1'b0, 1'b0, '0, '0, "read_0x10");
  endtask

  task automatic test_write();
    do_txn(1'b0, 32'h20, 32'h1234_5678, 2, 0, 1'b0, 1'b0, '0, '0, "write_0x20");
    do_txn(1'b1, 32'h20, '0, 3, 0, 1'b0, 1'b0, '0, '0, "readback_0x20");
  endtask

  task automatic test_timeout();
    do_txn(1'b1, 32'h30, '0, NEVER, 0, 1'b0, 1'b0, '0, '0, "timeout_never");
    do_txn(1'b1, 32'h34, '0, int'(TO) - 1, 0, 1'b0, 1'b0, '0, '0, "ready_on_terminal");
    do_txn(1'b0, 32'h38, 32'hDEAD_0001, int'(TO), 0, 1'b0, 1'b0, '0, '0, "ready_one_late");
    do_txn(1'b1, 32'h3C, '0, 0, 0, 1'b0, 1'b0, '0, '0, "ready_immediate");
  endtask

  task automatic test_backpressure();
    do_txn(1'b1, 32'h10, '0, 2, 5, 1'b1, 1'b1, 32'h40, '0, "rsp_hold5");
    do_txn(1'b1, 32'h40, '0, 2, 0, 1'b0, 1'b0, '0, '0, "held_second_cmd");
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 32'h100, '0, 2, 0, 1'b1, 1'b1, 32'h104, '0, "b2b_first");
    do_txn(1'b1, 32'h104, '0, 2, 0, 1'b0, 1'b0, '0, '0, "b2b_second");
  endtask

  task automatic test_stray_ready();
    stray = 1'b1;
    do_txn(1'b1, 32'h20, '0, 4, 3, 1'b0, 1'b0, '0, '0, "stray_ready");
    stray = 1'b0;
  endtask

  task automatic test_reset_mid();
    int bad;
    slave_lat = NEVER;
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h44; cmd_wdata = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    compared++;
    if (busc.valid !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_mid_start: bus_valid=%b, required 1", busc.valid);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (busc.valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_async: bus_valid=%b cmd_ready=%b rsp_valid=%b, required 0/1/0",
               busc.valid, cmd_ready, rsp_valid);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busc.valid !== 1'b0 || cmd_ready !== 1'b1) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL reset_mid_after: %0d bad cycles after release, required 0", bad);
    end
    slave_lat = 2;
  endtask

  task automatic test_random();
    localparam int N = 40;
    bit            rd  [N];
    logic [AW-1:0] ad  [N];
    logic [DW-1:0] wd  [N];
    int            lat [N];
    for (int i = 0; i < N; i++) begin
      rd[i]  = 1'($urandom_range(0, 1));
      ad[i]  = AW'(32'h200 + 4 * $urandom_range(0, 7));
      wd[i]  = $urandom;
      lat[i] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 18));
    end
    for (int i = 0; i < N; i++) begin
      bit ch;
      ch    = (i < N - 1) && ($urandom_range(0, 1) == 1);
      stray = 1'($urandom_range(0, 1));
      do_txn(rd[i], ad[i], wd[i], lat[i], int'($urandom_range(0, 3)), ch,
             (i < N - 1) ? rd[i+1] : 1'b0, (i < N - 1) ? ad[i+1] : '0, (i < N - 1) ? wd[i+1] : '0,
             $sformatf("rand%0d", i));
    end
    stray = 1'b0;
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_stray_ready();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
